// File: rtl/hazard_controller.sv
// Hazard controller for a 5-stage MIPS pipeline.
// Resolves load-use and mult/div (HI/LO) hazards by stalling, applies branch
// and jump flushes, sequences the multi-cycle mult/div unit, and counts
// stall cycles in a saturating counter.
module hazard_controller #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        IF_ID_Rs,
  input  logic [4:0]        IF_ID_Rt,
  input  logic              ID_UsesRs,
  input  logic              ID_UsesRt,
  input  logic [4:0]        ID_EX_Rt,
  input  logic              ID_EX_MemRead,
  input  logic              ID_Jump,
  input  logic              EX_BranchTaken,
  input  logic              ID_MulDivStart,
  input  logic              ID_IsDiv,
  input  logic              ID_ReadsHiLo,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic              IF_ID_Flush,
  output logic              ID_EX_Flush,
  output logic              MulDivStartOut,
  output logic              MulDivBusy,
  output logic              MulDivDone,
  output logic [PERF_W-1:0] StallCount
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Counter reload values: the op stays BUSY for cnt+1 cycles.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use_s;
  logic stall_s;
  logic flush_s;
  logic accept_s;
  logic busy_s;

  assign busy_s = (state_q == BUSY);

  // Hazard detection: load-use, HI/LO or second start while busy, branch flush.
  always_comb begin
    load_use_s = ID_EX_MemRead & (ID_EX_Rt != 5'd0) &
                 ((ID_UsesRs & (ID_EX_Rt == IF_ID_Rs)) |
                  (ID_UsesRt & (ID_EX_Rt == IF_ID_Rt)));
    stall_s    = load_use_s | (busy_s & (ID_ReadsHiLo | ID_MulDivStart));
    flush_s    = EX_BranchTaken;
    // A start is taken only if it is not stalled and not being discarded.
    accept_s   = ID_MulDivStart & ~stall_s & ~flush_s & ~rst;
  end

  // Pipeline control outputs: reset, then flush over stall over normal flow.
  always_comb begin
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    if (rst) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (flush_s) begin
      // The stalled instruction is squashed, so the front end keeps moving.
      PCWrite     = 1'b1;
      IF_ID_Write = 1'b1;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (stall_s) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      IF_ID_Flush = 1'b0;
      ID_EX_Flush = 1'b1;
    end else begin
      PCWrite     = 1'b1;
      IF_ID_Write = 1'b1;
      IF_ID_Flush = ID_Jump;
      ID_EX_Flush = 1'b0;
    end
  end

  // Mult/div FSM next state: load on accept, count down, pulse done on exit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = BUSY;
          cnt_d   = ID_IsDiv ? DIV_LOAD : MULT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Stall performance counter: count non-flushed stall cycles, saturating.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_s && !flush_s && (stall_cnt_q != PERF_MAX)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers; reset aborts any in-flight op without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      done_q      <= 1'b0;
      stall_cnt_q <= {PERF_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MulDivStartOut = accept_s;
  assign MulDivBusy     = busy_s;
  assign MulDivDone     = done_q;
  assign StallCount     = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: each driven cycle pushes its
// hand-derived expected outputs; a negedge monitor pops and compares.
module tb_hazard_controller;

  localparam int PW = 10;

  // Expected output vector: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
  //                          MulDivStartOut, MulDivBusy, MulDivDone}
  localparam logic [6:0] E_RST   = 7'b0011000;
  localparam logic [6:0] E_NORM  = 7'b1100000;
  localparam logic [6:0] E_JUMP  = 7'b1110000;
  localparam logic [6:0] E_STALL = 7'b0001000;
  localparam logic [6:0] E_FLUSH = 7'b1111000;
  localparam logic [6:0] E_START = 7'b0000100;
  localparam logic [6:0] E_BUSY  = 7'b0000010;
  localparam logic [6:0] E_DONE  = 7'b0000001;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    IF_ID_Rs, IF_ID_Rt, ID_EX_Rt;
  logic          ID_UsesRs, ID_UsesRt, ID_EX_MemRead, ID_Jump, EX_BranchTaken;
  logic          ID_MulDivStart, ID_IsDiv, ID_ReadsHiLo;
  logic          PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
  logic          MulDivStartOut, MulDivBusy, MulDivDone;
  logic [PW-1:0] StallCount;

  typedef struct {
    string         nm;
    logic [6:0]    o;
    logic [PW-1:0] sc;
  } exp_t;

  exp_t          sb_q[$];
  int            compared   = 0;
  int            mismatched = 0;
  logic [PW-1:0] sc_exp     = '0;

  hazard_controller #(
    .MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6), .PERF_W(PW)
  ) dut (
    .clk(clk), .rst(rst),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_EX_Rt(ID_EX_Rt), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_Jump(ID_Jump), .EX_BranchTaken(EX_BranchTaken),
    .ID_MulDivStart(ID_MulDivStart), .ID_IsDiv(ID_IsDiv),
    .ID_ReadsHiLo(ID_ReadsHiLo),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .MulDivStartOut(MulDivStartOut), .MulDivBusy(MulDivBusy),
    .MulDivDone(MulDivDone), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  // Monitor: compare the DUT against the oldest pending expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e   = sb_q.pop_front();
      act = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
             MulDivStartOut, MulDivBusy, MulDivDone};
      compared++;
      if (act !== e.o || StallCount !== e.sc) begin
        mismatched++;
        $display("FAIL %s: got out=%b cnt=%0d, expected out=%b cnt=%0d",
                 e.nm, act, StallCount, e.o, e.sc);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0; ID_EX_Rt = 5'd0;
    ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; ID_EX_MemRead = 1'b0;
    ID_Jump = 1'b0; EX_BranchTaken = 1'b0;
    ID_MulDivStart = 1'b0; ID_IsDiv = 1'b0; ID_ReadsHiLo = 1'b0;
  endtask

  // Queue this cycle's expectation, then advance the expected stall count:
  // a non-reset cycle with PCWrite low is a counted stall.
  task automatic push(input string nm, input logic [6:0] o);
    exp_t e;
    if (rst) sc_exp = '0;
    e.nm = nm; e.o = o; e.sc = sc_exp;
    sb_q.push_back(e);
    if (!rst && !o[6] && sc_exp != {PW{1'b1}}) sc_exp = sc_exp + PW'(1);
  endtask

  task automatic load_use_rs(input logic [4:0] r);
    ID_EX_MemRead = 1'b1; ID_EX_Rt = r; IF_ID_Rs = r; ID_UsesRs = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    next_cycle(); push("reset0", E_RST);
    next_cycle(); push("reset1", E_RST);
    next_cycle(); rst = 1'b0; push("idle", E_NORM);

    // Load-use on rs: one stall cycle, then the load has moved on.
    next_cycle(); set_idle(); load_use_rs(5'd2); push("lu_rs", E_STALL);
    next_cycle(); set_idle(); IF_ID_Rs = 5'd2; ID_UsesRs = 1'b1;
    push("lu_release", E_NORM);
    // Load-use on rt.
    next_cycle(); set_idle(); ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd7;
    IF_ID_Rt = 5'd7; ID_UsesRt = 1'b1; push("lu_rt", E_STALL);
    // $zero destination never hazards.
    next_cycle(); set_idle(); load_use_rs(5'd0); push("lu_r0", E_NORM);
    // Matching register that the ID instruction does not read.
    next_cycle(); set_idle(); load_use_rs(5'd9); ID_UsesRs = 1'b0;
    push("lu_unused", E_NORM);
    // Matching register but the EX instruction is not a load.
    next_cycle(); set_idle(); load_use_rs(5'd9); ID_EX_MemRead = 1'b0;
    push("lu_noload", E_NORM);

    // Jump with no hazard; jump under a stall keeps the stall.
    next_cycle(); set_idle(); ID_Jump = 1'b1; push("jump", E_JUMP);
    next_cycle(); set_idle(); ID_Jump = 1'b1; load_use_rs(5'd4);
    push("jump_stall", E_STALL);

    // MULT accepted, MFLO waits 4 busy cycles, proceeds in the done cycle.
    next_cycle(); set_idle(); ID_MulDivStart = 1'b1;
    push("mult_start", E_NORM | E_START);
    for (int i = 0; i < 4; i++) begin
      next_cycle(); set_idle(); ID_ReadsHiLo = 1'b1;
      push("mflo_stall", E_STALL | E_BUSY);
    end
    next_cycle(); set_idle(); ID_ReadsHiLo = 1'b1;
    push("mflo_go", E_NORM | E_DONE);
    next_cycle(); set_idle(); push("mult_idle", E_NORM);

    // DIV accepted; second DIV stalls the 32 busy cycles, starts on done.
    next_cycle(); set_idle(); ID_MulDivStart = 1'b1; ID_IsDiv = 1'b1;
    push("div_start", E_NORM | E_START);
    for (int i = 0; i < 32; i++) begin
      next_cycle(); set_idle(); ID_MulDivStart = 1'b1; ID_IsDiv = 1'b1;
      push("div2_stall", E_STALL | E_BUSY);
    end
    next_cycle(); set_idle(); ID_MulDivStart = 1'b1; ID_IsDiv = 1'b1;
    push("div2_start_on_done", E_NORM | E_START | E_DONE);
    for (int i = 0; i < 32; i++) begin
      next_cycle(); set_idle(); push("div2_busy", E_NORM | E_BUSY);
    end
    next_cycle(); set_idle(); push("div2_done", E_NORM | E_DONE);
    next_cycle(); set_idle(); push("div2_idle", E_NORM);

    // Branch flush beats load-use (no count) and cancels a start.
    next_cycle(); set_idle(); EX_BranchTaken = 1'b1; load_use_rs(5'd3);
    push("flush_lu", E_FLUSH);
    next_cycle(); set_idle(); EX_BranchTaken = 1'b1; ID_MulDivStart = 1'b1;
    push("flush_start", E_FLUSH);
    next_cycle(); set_idle(); push("flush_start_idle", E_NORM);
    // Branch flush does not abort a MULT already busy.
    next_cycle(); set_idle(); ID_MulDivStart = 1'b1;
    push("mult2_start", E_NORM | E_START);
    next_cycle(); set_idle(); EX_BranchTaken = 1'b1; ID_ReadsHiLo = 1'b1;
    push("flush_busy", E_FLUSH | E_BUSY);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); set_idle(); push("mult2_busy", E_NORM | E_BUSY);
    end
    next_cycle(); set_idle(); push("mult2_done", E_NORM | E_DONE);

    // Reset in BUSY cycle 10 of a DIV: busy drops at once, no done later.
    next_cycle(); set_idle(); ID_MulDivStart = 1'b1; ID_IsDiv = 1'b1;
    push("div3_start", E_NORM | E_START);
    for (int i = 0; i < 9; i++) begin
      next_cycle(); set_idle(); push("div3_busy", E_NORM | E_BUSY);
    end
    next_cycle(); set_idle(); rst = 1'b1; push("rst_mid_div", E_RST);
    next_cycle(); rst = 1'b0; push("rst_release", E_NORM);
    for (int i = 0; i < 30; i++) begin
      next_cycle(); set_idle(); push("no_done_after_rst", E_NORM);
    end

    // Drive 2^PW + 5 stall cycles: counter climbs then holds all-ones.
    for (int i = 0; i < (1 << PW) + 5; i++) begin
      next_cycle(); set_idle(); load_use_rs(5'd5); push("sat_stall", E_STALL);
    end
    next_cycle(); set_idle(); push("sat_hold", E_NORM);
    next_cycle(); set_idle(); push("sat_hold2", E_NORM);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
